// File: rtl/spi_seq_engine.sv
// spi_seq_engine: SPI display controller that pulses display reset, plays a ROM init program, then streams host bytes
// ROM_INIT packs the 10-bit entries {op,arg}; entry i sits at bits [10*i +: 10].
module spi_seq_engine #(
  parameter int DIV_FREQ_BY = 50,
  parameter int NUM_ENTRIES = 128,
  parameter logic [NUM_ENTRIES*10-1:0] ROM_INIT = {{(NUM_ENTRIES*10-10){1'b0}}, 10'h300},
  parameter int GAP_CYCLES = 4,
  parameter int DELAY_UNIT = 50000,
  parameter int RST_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_dc,
  output logic       s_ready,
  output logic       busy,
  output logic       init_done,
  output logic       rom_overrun,
  output logic       dc,
  output logic       mosi,
  output logic       cs,
  output logic       sck,
  output logic       reset_display
);
  typedef enum logic [3:0] {
    S_IDLE, S_RST_LOW, S_RST_WAIT, S_FETCH, S_DECODE, S_SHIFT, S_DELAY, S_GAP, S_READY
  } state_t;
  localparam int PW = $clog2(NUM_ENTRIES);
  localparam int PHW = $clog2(DIV_FREQ_BY);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_ENTRIES - 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(DIV_FREQ_BY - 1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(DIV_FREQ_BY / 2);
  localparam logic [31:0] C_RST = RST_CYCLES - 1;
  localparam logic [31:0] C_SHIFT = 8 * DIV_FREQ_BY - 1;
  localparam logic [31:0] C_GAP_I = GAP_CYCLES - 1;
  localparam logic [31:0] C_GAP_S = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;
  localparam logic [31:0] C_DU = DELAY_UNIT;
  state_t r_state, w_next;
  logic [31:0] r_cnt, w_delay_len;
  logic [PW-1:0] r_ptr;
  logic [PHW-1:0] r_ph;
  logic [9:0] r_rom_q;
  logic [7:0] r_sr;
  logic r_dc, r_stream, r_end, r_ovr, w_last, w_ovr_set;
  logic [9:0] w_rom [NUM_ENTRIES];
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_rom
    assign w_rom[g] = ROM_INIT[g*10 +: 10];
  end
  assign w_last = r_ptr == P_LAST;
  assign w_delay_len = {24'd0, r_rom_q[7:0]} * C_DU;
  // Next-state logic; stream bytes shorten GAP by one cycle because the READY handshake cycle also keeps cs high.
  always_comb begin
    w_next = r_state;
    w_ovr_set = 1'b0;
    case (r_state)
      S_IDLE:     w_next = start ? S_RST_LOW : S_IDLE;
      S_RST_LOW:  w_next = (r_cnt == C_RST) ? S_RST_WAIT : S_RST_LOW;
      S_RST_WAIT: w_next = (r_cnt == C_RST) ? S_FETCH : S_RST_WAIT;
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        if (r_rom_q[9:8] == 2'b11) w_next = S_READY;
        else if (r_rom_q[9:8] != 2'b10) w_next = S_SHIFT;
        else if (r_rom_q[7:0] != 8'd0) w_next = S_DELAY;
        else begin
          w_next = w_last ? S_READY : S_FETCH;
          w_ovr_set = w_last;
        end
      end
      S_SHIFT: if (r_cnt == C_SHIFT) w_next = (r_stream && GAP_CYCLES == 1) ? S_READY : S_GAP;
      S_GAP: if (r_cnt == (r_stream ? C_GAP_S : C_GAP_I)) begin
        w_next = (r_stream || r_end) ? S_READY : S_FETCH;
        w_ovr_set = !r_stream && r_end;
      end
      S_DELAY: if (r_cnt == w_delay_len - 32'd1) begin
        w_next = r_end ? S_READY : S_FETCH;
        w_ovr_set = r_end;
      end
      S_READY: w_next = start ? S_RST_LOW : (s_valid ? S_SHIFT : S_READY);
      default: w_next = S_IDLE;
    endcase
  end
  // State, counters, ROM read, pointer and shifter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_ptr <= '0;
      r_ph <= '0;
      r_rom_q <= '0;
      r_sr <= '0;
      r_dc <= 1'b1;
      r_stream <= 1'b0;
      r_end <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
      r_ovr <= r_ovr | w_ovr_set;
      if (r_state == S_FETCH) r_rom_q <= w_rom[r_ptr];
      if (w_next == S_RST_LOW && r_state != S_RST_LOW) begin
        r_ptr <= '0;
        r_end <= 1'b0;
      end
      if (r_state == S_DECODE) begin
        r_ptr <= w_last ? '0 : r_ptr + 1'b1;
        r_end <= r_end | w_last;
      end
      if (w_next == S_SHIFT && r_state != S_SHIFT) begin
        r_sr <= (r_state == S_READY) ? s_data : r_rom_q[7:0];
        r_dc <= (r_state == S_READY) ? s_dc : ~r_rom_q[8];
        r_stream <= r_state == S_READY;
        r_ph <= '0;
      end else if (r_state == S_SHIFT) begin
        r_ph <= (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
        if (r_ph == PH_LAST) r_sr <= {r_sr[6:0], 1'b0};
      end
    end
  end
  assign cs = r_state != S_SHIFT;
  assign sck = (r_state == S_SHIFT) && (r_ph >= PH_HALF);
  assign mosi = (r_state == S_SHIFT) && r_sr[7];
  assign dc = r_dc;
  assign reset_display = r_state != S_RST_LOW;
  assign busy = (r_state != S_IDLE) && (r_state != S_READY);
  assign init_done = r_state == S_READY;
  assign s_ready = (r_state == S_READY) && !start;
  assign rom_overrun = r_ovr;
endmodule
